// File: rtl/rule_cfg_arbiter.sv
// rule_cfg_arbiter
//   Configuration front end for the parser rule bus. Two requesters
//   (port 0 = host/PCIe, port 1 = on-chip CPU) are arbitrated round-robin.
//   Each accepted request becomes one single-cycle rule strobe, and exactly
//   one response pulse goes back to the requester. The layer field addr[25:24]
//   is validated, and reads are bounded by a timeout.
//
//   Optional build macro RULE_WR_CNT_EN: adds three 16-bit saturating write
//   counters, one per layer 0..2. A read to layer 3 returns the counter
//   selected by addr[1:0]. When the macro is undefined, layer 3 is always an
//   error.
//
// Ports
//   i_clk, i_rst_n            clock, async active-low reset
//   i_reqN_valid/we/addr/wdata  request from port N (N=0,1)
//   o_reqN_ready              combinational accept (valid & ready = handshake)
//   o_reqN_resp_valid/err/data  registered one-cycle response to port N
//   o_rule_wren/rden/addr/wdata registered strobes to the parser
//   i_rule_rdata_valid/rdata  read return from the parser
//
// state   | meaning
// IDLE    | waiting for a request; only state where ready can be high
// ISSUE   | rule strobe is on the bus this cycle
// WAIT_RD | waiting for parser read data; timeout counter running
// RESP    | response pulse is on the owner's resp port this cycle

module rule_cfg_arbiter #(
  parameter int RD_TIMEOUT = 16,
  parameter int TMO_W      = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic        i_req0_we,
  input  logic [31:0] i_req0_addr,
  input  logic [31:0] i_req0_wdata,
  output logic        o_req0_resp_valid,
  output logic        o_req0_resp_err,
  output logic [31:0] o_req0_resp_data,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic        i_req1_we,
  input  logic [31:0] i_req1_addr,
  input  logic [31:0] i_req1_wdata,
  output logic        o_req1_resp_valid,
  output logic        o_req1_resp_err,
  output logic [31:0] o_req1_resp_data,
  output logic        o_rule_wren,
  output logic        o_rule_rden,
  output logic [31:0] o_rule_addr,
  output logic [31:0] o_rule_wdata,
  input  logic        i_rule_rdata_valid,
  input  logic [31:0] i_rule_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic              grant;
  logic              hs;
  logic              owner, owner_nxt;
  logic              lat_we;
  logic [TMO_W-1:0]  tmr, tmr_nxt;
  logic              wren_nxt, rden_nxt;
  logic              resp_nxt;
  logic              rsp_err_nxt;
  logic [31:0]       rsp_data_nxt;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  // When both ports request, the port that did not win last time gets the grant.
  always_comb begin
    grant        = i_req1_valid & (~i_req0_valid | ~last_grant);
    o_req0_ready = (state == IDLE) & i_req0_valid & ~grant;
    o_req1_ready = (state == IDLE) & i_req1_valid & grant;
    hs           = o_req0_ready | o_req1_ready;
    req_we       = grant ? i_req1_we    : i_req0_we;
    req_addr     = grant ? i_req1_addr  : i_req0_addr;
    req_wdata    = grant ? i_req1_wdata : i_req0_wdata;
  end

`ifdef RULE_WR_CNT_EN
  logic [15:0] wr_cnt [3];
  logic [15:0] cnt_sel;

  always_comb begin
    cnt_sel = '0;
    case (req_addr[1:0])
      2'd0:    cnt_sel = wr_cnt[0];
      2'd1:    cnt_sel = wr_cnt[1];
      2'd2:    cnt_sel = wr_cnt[2];
      default: cnt_sel = '0;
    endcase
  end

  // Count writes as they are issued. o_rule_addr holds the address of the
  // write that is being issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) wr_cnt[i] <= '0;
    end else if (state == ISSUE && lat_we) begin
      for (int i = 0; i < 3; i++) begin
        if (o_rule_addr[25:24] == 2'(i) && wr_cnt[i] != 16'hFFFF)
          wr_cnt[i] <= wr_cnt[i] + 16'd1;
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // The read timer counts down from RD_TIMEOUT-2 as soon as it enters WAIT_RD.
  // Terminal count 0 is the last cycle in which parser data is still accepted.
  // An error response then follows RD_TIMEOUT cycles after the strobe.
  always_comb begin
    state_nxt    = state;
    tmr_nxt      = tmr;
    wren_nxt     = 1'b0;
    rden_nxt     = 1'b0;
    rsp_err_nxt  = 1'b0;
    rsp_data_nxt = '0;
    owner_nxt    = hs ? grant : owner;
    case (state)
      IDLE: begin
        if (hs) begin
          if (req_addr[25:24] == 2'd3) begin
            state_nxt   = RESP;
            rsp_err_nxt = 1'b1;
`ifdef RULE_WR_CNT_EN
            if (!req_we && req_addr[1:0] != 2'd3) begin
              rsp_err_nxt  = 1'b0;
              rsp_data_nxt = {16'h0, cnt_sel};
            end
`endif
          end else begin
            state_nxt = ISSUE;
            wren_nxt  = req_we;
            rden_nxt  = ~req_we;
          end
        end
      end
      ISSUE: begin
        if (lat_we) begin
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT_RD;
          tmr_nxt   = TMO_W'(RD_TIMEOUT - 2);
        end
      end
      WAIT_RD: begin
        if (i_rule_rdata_valid) begin
          state_nxt    = RESP;
          rsp_data_nxt = i_rule_rdata;
        end else if (tmr == '0) begin
          state_nxt   = RESP;
          rsp_err_nxt = 1'b1;
        end else begin
          tmr_nxt = tmr - TMO_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    resp_nxt = (state_nxt == RESP);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant        <= 1'b1;
      owner             <= 1'b0;
      lat_we            <= 1'b0;
      tmr               <= '0;
      o_rule_wren       <= 1'b0;
      o_rule_rden       <= 1'b0;
      o_rule_addr       <= '0;
      o_rule_wdata      <= '0;
      o_req0_resp_valid <= 1'b0;
      o_req0_resp_err   <= 1'b0;
      o_req0_resp_data  <= '0;
      o_req1_resp_valid <= 1'b0;
      o_req1_resp_err   <= 1'b0;
      o_req1_resp_data  <= '0;
    end else begin
      tmr         <= tmr_nxt;
      owner       <= owner_nxt;
      o_rule_wren <= wren_nxt;
      o_rule_rden <= rden_nxt;
      if (hs) begin
        last_grant <= grant;
        lat_we     <= req_we;
      end
      if (wren_nxt | rden_nxt) begin
        o_rule_addr  <= req_addr;
        o_rule_wdata <= req_wdata;
      end
      o_req0_resp_valid <= resp_nxt & ~owner_nxt;
      o_req0_resp_err   <= resp_nxt & ~owner_nxt & rsp_err_nxt;
      o_req0_resp_data  <= (resp_nxt & ~owner_nxt) ? rsp_data_nxt : '0;
      o_req1_resp_valid <= resp_nxt & owner_nxt;
      o_req1_resp_err   <= resp_nxt & owner_nxt & rsp_err_nxt;
      o_req1_resp_data  <= (resp_nxt & owner_nxt) ? rsp_data_nxt : '0;
    end
  end

endmodule

// File: tb/tb_rule_cfg_arbiter.sv
// Self-checking bench for rule_cfg_arbiter: directed cases plus random
// transactions, checked against a transaction-level model of the expected
// response cycle, error flag and data.
module tb_rule_cfg_arbiter;
  localparam int RD_TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic        req0_resp_valid, req0_resp_err;
  logic [31:0] req0_resp_data;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic        req1_resp_valid, req1_resp_err;
  logic [31:0] req1_resp_data;
  logic        rule_wren, rule_rden;
  logic [31:0] rule_addr, rule_wdata;
  logic        rule_rdata_valid;
  logic [31:0] rule_rdata;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_cnt [3];

  rule_cfg_arbiter #(.RD_TIMEOUT(RD_TIMEOUT), .TMO_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_we(req0_we),
    .i_req0_addr(req0_addr), .i_req0_wdata(req0_wdata),
    .o_req0_resp_valid(req0_resp_valid), .o_req0_resp_err(req0_resp_err),
    .o_req0_resp_data(req0_resp_data),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_we(req1_we),
    .i_req1_addr(req1_addr), .i_req1_wdata(req1_wdata),
    .o_req1_resp_valid(req1_resp_valid), .o_req1_resp_err(req1_resp_err),
    .o_req1_resp_data(req1_resp_data),
    .o_rule_wren(rule_wren), .o_rule_rden(rule_rden),
    .o_rule_addr(rule_addr), .o_rule_wdata(rule_wdata),
    .i_rule_rdata_valid(rule_rdata_valid), .i_rule_rdata(rule_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every write that reaches a parser layer bumps that layer's counter (saturating).
  task automatic model_write(input logic [31:0] addr);
    int l;
    l = int'(addr[25:24]);
    if (l < 3 && m_cnt[l] != 16'hFFFF) m_cnt[l] = m_cnt[l] + 16'd1;
  endtask

  // Runs one request from a single port. The parser model answers a read
  // k cycles after it sees rden (k=0 means it never answers).
  task automatic txn(input int port, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int k, input logic [31:0] rdata);
    int strobe_n, strobe_c, rd_c, resp_c, e_resp_c, e_strobe_n, layer;
    bit s_wr, other, both, r_err, e_err;
    logic [31:0] s_addr, s_wdata, r_data, e_data;
    layer = int'(addr[25:24]);
    e_err = 1'b0; e_data = '0; e_strobe_n = 1;
    if (layer == 3) begin
      e_strobe_n = 0; e_resp_c = 1; e_err = 1'b1;
`ifdef RULE_WR_CNT_EN
      if (!we && addr[1:0] != 2'd3) begin
        e_err = 1'b0;
        e_data = {16'h0, m_cnt[addr[1:0]]};
      end
`endif
    end else if (we) begin
      e_resp_c = 2;
      model_write(addr);
    end else if (k >= 1 && k <= RD_TIMEOUT - 1) begin
      e_resp_c = 2 + k; e_data = rdata;
    end else begin
      e_resp_c = RD_TIMEOUT + 1; e_err = 1'b1;
    end

    strobe_n = 0; strobe_c = -1; rd_c = -1; resp_c = -1;
    s_wr = 0; other = 0; both = 0; r_err = 0;
    s_addr = '0; s_wdata = '0; r_data = '0;
    @(negedge clk);
    if (port == 0) begin
      req0_valid = 1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = 1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
    #1;
    chk($sformatf("ready_p%0d", port), port == 0 ? req0_ready : req1_ready, 1);
    for (int c = 1; c <= 40 && resp_c < 0; c++) begin
      @(negedge clk);
      if (rule_wren | rule_rden) begin
        strobe_n++; strobe_c = c; s_wr = rule_wren;
        s_addr = rule_addr; s_wdata = rule_wdata;
        if (rule_wren & rule_rden) both = 1;
      end
      if (rule_rden) rd_c = c;
      if (port == 0) begin
        if (req0_resp_valid) begin resp_c = c; r_err = req0_resp_err; r_data = req0_resp_data; end
        if (req1_resp_valid) other = 1;
      end else begin
        if (req1_resp_valid) begin resp_c = c; r_err = req1_resp_err; r_data = req1_resp_data; end
        if (req0_resp_valid) other = 1;
      end
      req0_valid = 0; req1_valid = 0;
      if (we || layer == 3) begin
        rule_rdata_valid = 1'($urandom_range(0, 1));
        rule_rdata = $urandom;
      end else begin
        rule_rdata_valid = (rd_c > 0 && k > 0 && c == rd_c + k);
        rule_rdata = rule_rdata_valid ? rdata : $urandom;
      end
    end
    rule_rdata_valid = 0;
    chk("resp_cycle", resp_c, e_resp_c);
    chk("resp_err", {31'd0, r_err}, {31'd0, e_err});
    chk("resp_data", r_data, e_data);
    chk("strobe_count", strobe_n, e_strobe_n);
    chk("other_port_resp", {31'd0, other}, 0);
    chk("wren_rden_together", {31'd0, both}, 0);
    if (e_strobe_n == 1) begin
      chk("strobe_cycle", strobe_c, 1);
      chk("strobe_is_write", {31'd0, s_wr}, {31'd0, we});
      chk("strobe_addr", s_addr, addr);
      chk("strobe_wdata", s_wdata, wdata);
    end
  endtask

  initial begin
    int w_n, r0_c, r1_c, p1_c, rsp_n;
    int w_c [2];
    logic [31:0] w_a [2];
    logic [31:0] w_d [2];
    logic [31:0] a;
    for (int i = 0; i < 3; i++) m_cnt[i] = '0;
    rst_n = 0;
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    rule_rdata_valid = 0; rule_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {30'd0, rule_wren, rule_rden}, 0);
    chk("rst_rule_addr", rule_addr, 0);
    chk("rst_rule_wdata", rule_wdata, 0);
    chk("rst_resp", {28'd0, req0_resp_valid, req0_resp_err, req1_resp_valid, req1_resp_err}, 0);
    chk("rst_resp_data", req0_resp_data | req1_resp_data, 0);
    rst_n = 1;

    // Both ports request together after reset: port 0 first, then port 1.
    @(negedge clk);
    req0_valid = 1; req0_we = 1; req0_addr = 32'h0000_0010; req0_wdata = 32'h1111_0000;
    req1_valid = 1; req1_we = 1; req1_addr = 32'h0200_0020; req1_wdata = 32'h2222_0000;
    #1;
    chk("arb_ready0", {31'd0, req0_ready}, 1);
    chk("arb_ready1", {31'd0, req1_ready}, 0);
    model_write(32'h0000_0010);
    model_write(32'h0200_0020);
    w_n = 0; r0_c = -1; r1_c = -1; p1_c = -1;
    w_c[0] = -1; w_c[1] = -1; w_a[0] = '0; w_a[1] = '0; w_d[0] = '0; w_d[1] = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rule_wren) begin
        if (w_n < 2) begin w_c[w_n] = c; w_a[w_n] = rule_addr; w_d[w_n] = rule_wdata; end
        w_n++;
      end
      if (req0_resp_valid) r0_c = c;
      if (req1_resp_valid) r1_c = c;
      if (req1_valid && req1_ready && p1_c < 0) p1_c = c;
      req0_valid = 0;
      if (p1_c > 0 && c > p1_c) req1_valid = 0;
    end
    req1_valid = 0;
    chk("arb_wr_count", w_n, 2);
    chk("arb_wr0_cycle", w_c[0], 1);
    chk("arb_wr0_addr", w_a[0], 32'h0000_0010);
    chk("arb_wr0_data", w_d[0], 32'h1111_0000);
    chk("arb_resp0_cycle", r0_c, 2);
    chk("arb_hs1_cycle", p1_c, 3);
    chk("arb_wr1_cycle", w_c[1], 4);
    chk("arb_wr1_addr", w_a[1], 32'h0200_0020);
    chk("arb_wr1_data", w_d[1], 32'h2222_0000);
    chk("arb_resp1_cycle", r1_c, 5);

    // Directed cases.
    txn(0, 1, 32'h0100_0004, 32'hA5A5_0001, 0, 0);
    txn(1, 0, 32'h0200_0008, 32'h0, 3, 32'h1234_5678);
    txn(0, 0, 32'h0000_0100, 32'h0, 0, 32'h0);
    txn(1, 1, 32'h0100_0200, 32'hCAFE_0001, 0, 0);
    txn(0, 0, 32'h0100_0300, 32'h0, RD_TIMEOUT - 1, 32'hBEEF_0015);
    txn(1, 0, 32'h0200_0400, 32'h0, RD_TIMEOUT, 32'hBEEF_0016);
    txn(0, 0, 32'h0000_0500, 32'h0, 1, 32'h0000_0001);
    txn(0, 1, 32'h0300_0000, 32'hDEAD_0000, 0, 0);
    txn(1, 0, 32'h0300_0003, 32'h0, 2, 32'h5555_5555);
    txn(1, 1, 32'h0100_0600, 32'h0000_0A01, 0, 0);
    txn(0, 1, 32'h0100_0700, 32'h0000_0A02, 0, 0);
    txn(0, 0, 32'h0300_0001, 32'h0, 2, 32'h7777_7777);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[25:24] = 2'd3;
      txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
          int'($urandom_range(0, RD_TIMEOUT + 1)), $urandom);
    end

    // Reset while a read is waiting for the parser.
    @(negedge clk);
    req0_valid = 1; req0_we = 0; req0_addr = 32'h0000_0040; req0_wdata = '0;
    #1;
    chk("rst_test_ready", {31'd0, req0_ready}, 1);
    rsp_n = 0; w_n = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (rule_rden) w_n++;
      req0_valid = 0;
    end
    chk("rst_test_rden_seen", w_n, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_strobes", {30'd0, rule_wren, rule_rden}, 0);
    chk("mid_rst_addr", rule_addr | rule_wdata, 0);
    chk("mid_rst_resp", {30'd0, req0_resp_valid, req1_resp_valid}, 0);
    chk("mid_rst_ready", {30'd0, req0_ready, req1_ready}, 0);
    for (int i = 0; i < 3; i++) m_cnt[i] = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req0_resp_valid | req1_resp_valid) rsp_n++;
      if (c == 2) rst_n = 1;
    end
    chk("no_resp_after_abort", rsp_n, 0);
    txn(0, 1, 32'h0100_0800, 32'h0BAD_F00D, 0, 0);
    txn(0, 0, 32'h0300_0001, 32'h0, 2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
